// File: rtl/coherence_bus_rr_pkg.sv
// Shared types for the snooping coherence bus: bus request opcodes and the
// transaction FSM states.
package coherence_bus_rr_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_req_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SNOOP      = 3'd1,
    SNOOP_RESP = 3'd2,
    L2_REQ     = 3'd3,
    L2_WAIT    = 3'd4,
    RESP       = 3'd5,
    ACK        = 3'd6
  } bus_state_t;

endpackage

// File: rtl/coherence_bus_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after rr_ptr and moves
// the pointer past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ID_BITS   = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 advance,
  output logic [NUM_CORES-1:0] grant,
  output logic [ID_BITS-1:0]   grant_id,
  output logic                 any_req
);

  logic [ID_BITS-1:0] rr_ptr;
  int                 cand;

  // Scan from the farthest offset down so the nearest request to rr_ptr wins.
  always_comb begin
    grant_id = '0;
    any_req  = 1'b0;
    cand     = 0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (req[ID_BITS'(cand)]) begin
        grant_id = ID_BITS'(cand);
        any_req  = 1'b1;
      end
    end
    grant = any_req ? (NUM_CORES'(1) << grant_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance && any_req) begin
      rr_ptr <= (grant_id == ID_BITS'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/coherence_bus_rr.sv
// Snooping coherence bus: serialises one L1 transaction at a time, snoops the
// peers, and sources the line from a peer cache or L2 (flushing dirty lines).
module coherence_bus_rr
  import coherence_bus_rr_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int LINE_ADDR_BITS = 26,
  parameter int LINE_BITS      = 512,
  parameter int ID_BITS        = $clog2(NUM_CORES)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic     [NUM_CORES-1:0]                 l1_req_valid,
  output logic     [NUM_CORES-1:0]                 l1_req_ready,
  input  bus_req_t [NUM_CORES-1:0]                 l1_req,
  input  logic     [NUM_CORES-1:0][LINE_ADDR_BITS-1:0] l1_req_addr,
  input  logic     [NUM_CORES-1:0][LINE_BITS-1:0]  l1_req_data,
  output logic                                     l1_resp_valid,
  output logic     [ID_BITS-1:0]                   l1_resp_id,
  output logic     [LINE_BITS-1:0]                 l1_resp_data,
  output logic                                     l1_resp_shared,
  output logic     [NUM_CORES-1:0]                 l1_snoop_valid,
  output logic     [LINE_ADDR_BITS-1:0]            l1_snoop_addr,
  output bus_req_t                                 l1_snoop_req,
  input  logic     [NUM_CORES-1:0]                 l1_snoop_shared,
  input  logic     [NUM_CORES-1:0]                 l1_snoop_dirty,
  input  logic     [NUM_CORES-1:0][LINE_BITS-1:0]  l1_snoop_data,
  output logic                                     l2_req_valid,
  input  logic                                     l2_req_ready,
  output logic                                     l2_req_rw,
  output logic     [LINE_ADDR_BITS-1:0]            l2_req_addr,
  output logic     [LINE_BITS-1:0]                 l2_req_data,
  input  logic                                     l2_resp_valid,
  input  logic     [LINE_BITS-1:0]                 l2_resp_data
);

  bus_state_t                state;
  bus_state_t                state_next;
  bus_req_t                  lat_req;
  logic [LINE_ADDR_BITS-1:0] lat_addr;
  logic [LINE_BITS-1:0]      line_q;
  logic [ID_BITS-1:0]        lat_id;
  logic                      l2_rw_q;

  logic [NUM_CORES-1:0]      arb_grant;
  logic [ID_BITS-1:0]        arb_id;
  logic                      arb_any;

  logic [NUM_CORES-1:0]      req_mask;
  logic [NUM_CORES-1:0]      peer_dirty;
  logic [NUM_CORES-1:0]      peer_shared;
  logic                      any_dirty;
  logic                      any_shared;
  logic [ID_BITS-1:0]        dirty_id;
  logic [ID_BITS-1:0]        shared_id;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES),
    .ID_BITS  (ID_BITS)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (l1_req_valid),
    .advance (state == IDLE),
    .grant   (arb_grant),
    .grant_id(arb_id),
    .any_req (arb_any)
  );

  // A dirty peer also counts as holding the line; the requester never answers itself.
  assign req_mask    = NUM_CORES'(1) << lat_id;
  assign peer_dirty  = l1_snoop_dirty & ~req_mask;
  assign peer_shared = (l1_snoop_shared | l1_snoop_dirty) & ~req_mask;
  assign any_dirty   = |peer_dirty;
  assign any_shared  = |peer_shared;

  always_comb begin
    dirty_id  = '0;
    shared_id = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (peer_dirty[i])  dirty_id  = ID_BITS'(i);
      if (peer_shared[i]) shared_id = ID_BITS'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A read miss already raises l2_req_valid in SNOOP_RESP, so an immediate
  // l2_req_ready there skips straight to L2_WAIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (arb_any) state_next = SNOOP;
      SNOOP: begin
        case (lat_req)
          BUS_UPGR: state_next = ACK;
          BUS_WB:   state_next = L2_REQ;
          default:  state_next = SNOOP_RESP;
        endcase
      end
      SNOOP_RESP: begin
        if (any_dirty)         state_next = L2_REQ;
        else if (any_shared)   state_next = IDLE;
        else if (l2_req_ready) state_next = L2_WAIT;
        else                   state_next = L2_REQ;
      end
      L2_REQ:     if (l2_req_ready) state_next = l2_rw_q ? IDLE : L2_WAIT;
      L2_WAIT:    if (l2_resp_valid) state_next = RESP;
      RESP:       state_next = IDLE;
      ACK:        state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_req  <= BUS_RD;
      lat_addr <= '0;
      line_q   <= '0;
      lat_id   <= '0;
      l2_rw_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            lat_req  <= l1_req[arb_id];
            lat_addr <= l1_req_addr[arb_id];
            line_q   <= l1_req_data[arb_id];
            lat_id   <= arb_id;
            l2_rw_q  <= 1'b0;
          end
        end
        SNOOP: begin
          if (lat_req == BUS_WB) l2_rw_q <= 1'b1;
        end
        SNOOP_RESP: begin
          if (any_dirty) begin
            line_q  <= l1_snoop_data[dirty_id];
            l2_rw_q <= 1'b1;
          end else begin
            l2_rw_q <= 1'b0;
          end
        end
        L2_WAIT: begin
          if (l2_resp_valid) line_q <= l2_resp_data;
        end
        default: ;
      endcase
    end
  end

  assign l1_snoop_addr = lat_addr;
  assign l1_snoop_req  = lat_req;
  assign l1_resp_id    = lat_id;

  always_comb begin
    l1_req_ready   = '0;
    l1_snoop_valid = '0;
    l1_resp_valid  = 1'b0;
    l1_resp_data   = '0;
    l1_resp_shared = 1'b0;
    l2_req_valid   = 1'b0;
    l2_req_rw      = 1'b0;
    l2_req_addr    = '0;
    l2_req_data    = '0;
    case (state)
      IDLE:  l1_req_ready   = arb_grant;
      SNOOP: l1_snoop_valid = ~req_mask;
      SNOOP_RESP: begin
        if (any_shared) begin
          l1_resp_valid  = 1'b1;
          l1_resp_data   = any_dirty ? l1_snoop_data[dirty_id] : l1_snoop_data[shared_id];
          l1_resp_shared = (lat_req == BUS_RD);
        end else begin
          l2_req_valid = 1'b1;
          l2_req_addr  = lat_addr;
        end
      end
      L2_REQ: begin
        l2_req_valid = 1'b1;
        l2_req_rw    = l2_rw_q;
        l2_req_addr  = lat_addr;
        l2_req_data  = l2_rw_q ? line_q : '0;
      end
      RESP: begin
        l1_resp_valid = 1'b1;
        l1_resp_data  = line_q;
      end
      ACK:     l1_resp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_rr.sv
// Directed bench for coherence_bus_rr: peer hits, dirty flush, L2 miss,
// upgrade/writeback, round-robin order and mid-transaction reset.
module tb_coherence_bus_rr;
  import coherence_bus_rr_pkg::*;

  localparam int NC = 4;
  localparam int AB = 26;
  localparam int LB = 512;
  localparam int IB = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic     [NC-1:0]        l1_req_valid;
  logic     [NC-1:0]        l1_req_ready;
  bus_req_t [NC-1:0]        l1_req;
  logic     [NC-1:0][AB-1:0] l1_req_addr;
  logic     [NC-1:0][LB-1:0] l1_req_data;
  logic                     l1_resp_valid;
  logic     [IB-1:0]        l1_resp_id;
  logic     [LB-1:0]        l1_resp_data;
  logic                     l1_resp_shared;
  logic     [NC-1:0]        l1_snoop_valid;
  logic     [AB-1:0]        l1_snoop_addr;
  bus_req_t                 l1_snoop_req;
  logic     [NC-1:0]        l1_snoop_shared;
  logic     [NC-1:0]        l1_snoop_dirty;
  logic     [NC-1:0][LB-1:0] l1_snoop_data;
  logic                     l2_req_valid;
  logic                     l2_req_ready;
  logic                     l2_req_rw;
  logic     [AB-1:0]        l2_req_addr;
  logic     [LB-1:0]        l2_req_data;
  logic                     l2_resp_valid;
  logic     [LB-1:0]        l2_resp_data;

  int assertCount = 0;
  int failCount   = 0;
  logic [NC-1:0] expGrant [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
  logic [NC-1:0] gotGrant;

  coherence_bus_rr #(
    .NUM_CORES     (NC),
    .LINE_ADDR_BITS(AB),
    .LINE_BITS     (LB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .l1_req_valid   (l1_req_valid),
    .l1_req_ready   (l1_req_ready),
    .l1_req         (l1_req),
    .l1_req_addr    (l1_req_addr),
    .l1_req_data    (l1_req_data),
    .l1_resp_valid  (l1_resp_valid),
    .l1_resp_id     (l1_resp_id),
    .l1_resp_data   (l1_resp_data),
    .l1_resp_shared (l1_resp_shared),
    .l1_snoop_valid (l1_snoop_valid),
    .l1_snoop_addr  (l1_snoop_addr),
    .l1_snoop_req   (l1_snoop_req),
    .l1_snoop_shared(l1_snoop_shared),
    .l1_snoop_dirty (l1_snoop_dirty),
    .l1_snoop_data  (l1_snoop_data),
    .l2_req_valid   (l2_req_valid),
    .l2_req_ready   (l2_req_ready),
    .l2_req_rw      (l2_req_rw),
    .l2_req_addr    (l2_req_addr),
    .l2_req_data    (l2_req_data),
    .l2_resp_valid  (l2_resp_valid),
    .l2_resp_data   (l2_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [LB-1:0] pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic checkOutput(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int core, input bus_req_t kind,
                               input logic [AB-1:0] addr, input logic [LB-1:0] data);
    l1_req_valid[core] = 1'b1;
    l1_req[core]       = kind;
    l1_req_addr[core]  = addr;
    l1_req_data[core]  = data;
  endtask

  task automatic dropRequest(input int core);
    l1_req_valid[core] = 1'b0;
  endtask

  task automatic clearSnoop();
    l1_snoop_shared = '0;
    l1_snoop_dirty  = '0;
    l1_snoop_data   = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrant(output logic [NC-1:0] g);
    g = '0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (l1_req_ready != '0) begin
        g = l1_req_ready;
        nextCycle();
        break;
      end
      nextCycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    l1_req_valid  = '0;
    l1_req        = '{default: BUS_RD};
    l1_req_addr   = '0;
    l1_req_data   = '0;
    l2_req_ready  = 1'b0;
    l2_resp_valid = 1'b0;
    l2_resp_data  = '0;
    clearSnoop();

    // Reset state
    repeat (3) nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rst_ready",      l1_req_ready,   '0);
    checkOutput("rst_resp_valid", l1_resp_valid,  '0);
    checkOutput("rst_resp_id",    l1_resp_id,     '0);
    checkOutput("rst_resp_data",  l1_resp_data,   '0);
    checkOutput("rst_snoop_v",    l1_snoop_valid, '0);
    checkOutput("rst_snoop_addr", l1_snoop_addr,  '0);
    checkOutput("rst_l2_valid",   l2_req_valid,   '0);
    checkOutput("rst_l2_addr",    l2_req_addr,    '0);
    checkOutput("rst_l2_data",    l2_req_data,    '0);

    // Shared hit: core 1 reads 0x100, core 3 shares; requester's own bits ignored
    nextCycle();
    applyStimulus(1, BUS_RD, 26'h100, pat(8'h11));
    l1_snoop_shared  = 4'b1010;
    l1_snoop_dirty   = 4'b0010;
    l1_snoop_data[3] = pat(8'hA5);
    l1_snoop_data[1] = pat(8'hFF);
    #1;
    checkOutput("sh_grant", l1_req_ready, 4'b0010);
    nextCycle();
    dropRequest(1);
    #1;
    checkOutput("sh_snoop_valid", l1_snoop_valid, 4'b1101);
    checkOutput("sh_snoop_addr",  l1_snoop_addr,  26'h100);
    checkOutput("sh_snoop_req",   l1_snoop_req,   BUS_RD);
    checkOutput("sh_ready_busy",  l1_req_ready,   '0);
    nextCycle();
    #1;
    checkOutput("sh_resp_valid",  l1_resp_valid,  1'b1);
    checkOutput("sh_resp_id",     l1_resp_id,     2'd1);
    checkOutput("sh_resp_data",   l1_resp_data,   pat(8'hA5));
    checkOutput("sh_resp_shared", l1_resp_shared, 1'b1);
    checkOutput("sh_no_l2",       l2_req_valid,   1'b0);
    nextCycle();
    clearSnoop();
    #1;
    checkOutput("sh_idle_resp", l1_resp_valid, 1'b0);
    checkOutput("sh_idle_l2",   l2_req_valid,  1'b0);

    // Dirty flush: core 0 RDX, cores 2 and 3 dirty, core 2 wins
    nextCycle();
    applyStimulus(0, BUS_RDX, 26'h2A, pat(8'h22));
    l1_snoop_shared  = 4'b1100;
    l1_snoop_dirty   = 4'b1100;
    l1_snoop_data[2] = pat(8'hB2);
    l1_snoop_data[3] = pat(8'hC3);
    #1;
    checkOutput("dy_grant", l1_req_ready, 4'b0001);
    nextCycle();
    dropRequest(0);
    #1;
    checkOutput("dy_snoop_valid", l1_snoop_valid, 4'b1110);
    checkOutput("dy_snoop_req",   l1_snoop_req,   BUS_RDX);
    nextCycle();
    #1;
    checkOutput("dy_resp_valid",  l1_resp_valid,  1'b1);
    checkOutput("dy_resp_id",     l1_resp_id,     2'd0);
    checkOutput("dy_resp_data",   l1_resp_data,   pat(8'hB2));
    checkOutput("dy_resp_shared", l1_resp_shared, 1'b0);
    checkOutput("dy_no_l2_yet",   l2_req_valid,   1'b0);
    nextCycle();
    clearSnoop();
    l2_req_ready = 1'b1;
    #1;
    checkOutput("dy_l2_valid", l2_req_valid,  1'b1);
    checkOutput("dy_l2_rw",    l2_req_rw,     1'b1);
    checkOutput("dy_l2_addr",  l2_req_addr,   26'h2A);
    checkOutput("dy_l2_data",  l2_req_data,   pat(8'hB2));
    checkOutput("dy_no_resp",  l1_resp_valid, 1'b0);
    nextCycle();
    l2_req_ready = 1'b0;
    #1;
    checkOutput("dy_idle_l2",   l2_req_valid,  1'b0);
    checkOutput("dy_idle_resp", l1_resp_valid, 1'b0);

    // L2 miss: core 2 reads 0x3C, ready delayed 3 cycles, data 5 cycles later
    nextCycle();
    applyStimulus(2, BUS_RD, 26'h3C, pat(8'h33));
    #1;
    checkOutput("ms_grant", l1_req_ready, 4'b0100);
    nextCycle();
    dropRequest(2);
    #1;
    checkOutput("ms_snoop_no_l2", l2_req_valid, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      nextCycle();
      #1;
      checkOutput($sformatf("ms_l2_valid_c%0d", k), l2_req_valid,  1'b1);
      checkOutput($sformatf("ms_l2_addr_c%0d", k),  l2_req_addr,   26'h3C);
      checkOutput($sformatf("ms_l2_rw_c%0d", k),    l2_req_rw,     1'b0);
      checkOutput($sformatf("ms_no_resp_c%0d", k),  l1_resp_valid, 1'b0);
    end
    nextCycle();
    l2_req_ready = 1'b1;
    #1;
    checkOutput("ms_l2_valid_c5", l2_req_valid, 1'b1);
    checkOutput("ms_l2_addr_c5",  l2_req_addr,  26'h3C);
    nextCycle();
    l2_req_ready = 1'b0;
    #1;
    checkOutput("ms_wait_l2_low", l2_req_valid, 1'b0);
    for (int k = 7; k <= 9; k++) begin
      nextCycle();
      #1;
      checkOutput($sformatf("ms_wait_resp_c%0d", k), l1_resp_valid, 1'b0);
    end
    nextCycle();
    l2_resp_valid = 1'b1;
    l2_resp_data  = pat(8'hD4);
    #1;
    checkOutput("ms_resp_not_early", l1_resp_valid, 1'b0);
    nextCycle();
    l2_resp_valid = 1'b0;
    l2_resp_data  = '0;
    #1;
    checkOutput("ms_resp_valid",  l1_resp_valid,  1'b1);
    checkOutput("ms_resp_id",     l1_resp_id,     2'd2);
    checkOutput("ms_resp_data",   l1_resp_data,   pat(8'hD4));
    checkOutput("ms_resp_shared", l1_resp_shared, 1'b0);
    nextCycle();
    #1;
    checkOutput("ms_resp_pulse", l1_resp_valid, 1'b0);

    // Round-robin: pointer is 3, cores 0 and 2 request continuously
    nextCycle();
    l2_req_ready  = 1'b1;
    l2_resp_valid = 1'b1;
    l2_resp_data  = pat(8'hE5);
    applyStimulus(0, BUS_RD, 26'h10, pat(8'h01));
    applyStimulus(2, BUS_RD, 26'h20, pat(8'h02));
    for (int k = 0; k < 4; k++) begin
      waitGrant(gotGrant);
      checkOutput($sformatf("rr_grant_%0d", k), gotGrant, expGrant[k]);
    end
    dropRequest(0);
    dropRequest(2);
    repeat (5) nextCycle();
    l2_req_ready  = 1'b0;
    l2_resp_valid = 1'b0;
    l2_resp_data  = '0;

    // Upgrade: core 1, a sharer present but the ack carries no data
    nextCycle();
    applyStimulus(1, BUS_UPGR, 26'h55, pat(8'h44));
    l1_snoop_shared  = 4'b1000;
    l1_snoop_data[3] = pat(8'hA5);
    #1;
    checkOutput("up_grant", l1_req_ready, 4'b0010);
    nextCycle();
    dropRequest(1);
    #1;
    checkOutput("up_snoop_valid", l1_snoop_valid, 4'b1101);
    checkOutput("up_snoop_req",   l1_snoop_req,   BUS_UPGR);
    nextCycle();
    #1;
    checkOutput("up_resp_valid",  l1_resp_valid,  1'b1);
    checkOutput("up_resp_id",     l1_resp_id,     2'd1);
    checkOutput("up_resp_data",   l1_resp_data,   '0);
    checkOutput("up_resp_shared", l1_resp_shared, 1'b0);
    checkOutput("up_no_l2",       l2_req_valid,   1'b0);
    nextCycle();
    clearSnoop();
    #1;
    checkOutput("up_idle_resp", l1_resp_valid, 1'b0);

    // Writeback: core 3 writes 0x77, no L1 response
    nextCycle();
    applyStimulus(3, BUS_WB, 26'h77, pat(8'hE7));
    #1;
    checkOutput("wb_grant", l1_req_ready, 4'b1000);
    nextCycle();
    dropRequest(3);
    #1;
    checkOutput("wb_snoop_valid", l1_snoop_valid, 4'b0111);
    checkOutput("wb_snoop_req",   l1_snoop_req,   BUS_WB);
    nextCycle();
    l2_req_ready = 1'b1;
    #1;
    checkOutput("wb_l2_valid", l2_req_valid,  1'b1);
    checkOutput("wb_l2_rw",    l2_req_rw,     1'b1);
    checkOutput("wb_l2_addr",  l2_req_addr,   26'h77);
    checkOutput("wb_l2_data",  l2_req_data,   pat(8'hE7));
    checkOutput("wb_no_resp",  l1_resp_valid, 1'b0);
    nextCycle();
    l2_req_ready = 1'b0;
    #1;
    checkOutput("wb_idle_l2",   l2_req_valid,  1'b0);
    checkOutput("wb_idle_resp", l1_resp_valid, 1'b0);

    // Reset in L2_WAIT, then a stray l2_resp_valid
    nextCycle();
    applyStimulus(2, BUS_RD, 26'h99, pat(8'h55));
    l2_req_ready = 1'b1;
    #1;
    checkOutput("rw_grant", l1_req_ready, 4'b0100);
    nextCycle();
    dropRequest(2);
    #1;
    nextCycle();
    #1;
    checkOutput("rw_l2_early", l2_req_valid, 1'b1);
    nextCycle();
    l2_req_ready = 1'b0;
    reset        = 1'b1;
    #1;
    checkOutput("rw_in_wait", l2_req_valid, 1'b0);
    nextCycle();
    reset         = 1'b0;
    l2_resp_valid = 1'b1;
    l2_resp_data  = pat(8'h66);
    #1;
    checkOutput("rw_resp_valid", l1_resp_valid,  1'b0);
    checkOutput("rw_ready",      l1_req_ready,   '0);
    checkOutput("rw_snoop_v",    l1_snoop_valid, '0);
    checkOutput("rw_l2_valid",   l2_req_valid,   1'b0);
    checkOutput("rw_resp_id",    l1_resp_id,     '0);
    checkOutput("rw_snoop_addr", l1_snoop_addr,  '0);
    nextCycle();
    #1;
    checkOutput("rw_stray_ignored", l1_resp_valid, 1'b0);
    nextCycle();
    l2_resp_valid = 1'b0;
    l2_resp_data  = '0;
    applyStimulus(1, BUS_RD, 26'h123, pat(8'h0A));
    applyStimulus(3, BUS_RD, 26'h321, pat(8'h0B));
    l1_snoop_shared  = 4'b0001;
    l1_snoop_data[0] = pat(8'h77);
    #1;
    checkOutput("rw_regrant", l1_req_ready, 4'b0010);
    nextCycle();
    dropRequest(1);
    dropRequest(3);
    #1;
    nextCycle();
    #1;
    checkOutput("rw_resp_valid2", l1_resp_valid, 1'b1);
    checkOutput("rw_resp_id2",    l1_resp_id,    2'd1);
    checkOutput("rw_resp_data2",  l1_resp_data,  pat(8'h77));
    nextCycle();
    clearSnoop();
    repeat (2) nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/coherence_bus_rr.md
# coherence_bus_rr

Parametrised snooping coherence bus between `NUM_CORES` private L1 controllers and the shared L2. It serialises one bus transaction at a time and uses round-robin arbitration. It broadcasts snoops to all non-requesting cores and sources the line from a peer cache or from L2. When a peer supplies dirty data, the bus also writes that line back to L2 (flush). Responses carry the requester ID, and BUS_UPGR is explicitly acknowledged.

## Interface
- `NUM_CORES`, 4: number of L1 ports; ≥2.
- `LINE_ADDR_BITS`, 26: line address width (address minus offset bits).
- `LINE_BITS`, 512: cache line width.
- `ID_BITS`, derived `$clog2(NUM_CORES)`: core index width.
- Reset is synchronous and active-high.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `l1_req_valid`  in  NUM_CORES  per-core request; held until granted.
- `l1_req_ready`  out  NUM_CORES  one-hot, one-cycle grant.
- `l1_req`  in  NUM_CORES×bus_req_t  BUS_RD / BUS_RDX / BUS_UPGR / BUS_WB.
- `l1_req_addr`  in  NUM_CORES×LINE_ADDR_BITS  line address.
- `l1_req_data`  in  NUM_CORES×LINE_BITS  writeback data (BUS_WB only).
- `l1_resp_valid`  out  1  one-cycle response pulse.
- `l1_resp_id`  out  ID_BITS  index of the core the response belongs to.
- `l1_resp_data`  out  LINE_BITS  line data; 0 for the UPGR ack.
- `l1_resp_shared`  out  1  peer retains a copy; BUS_RD only.
- `l1_snoop_valid`  out  NUM_CORES  snoop strobe; requester bit always 0.
- `l1_snoop_addr`  out  LINE_ADDR_BITS  latched address.
- `l1_snoop_req`  out  bus_req_t  latched request type.
- `l1_snoop_shared`  in  NUM_CORES  peer holds the line; valid in the cycle after the snoop.
- `l1_snoop_dirty`  in  NUM_CORES  peer holds the line Modified; implies shared.
- `l1_snoop_data`  in  NUM_CORES×LINE_BITS  peer line data.
- `l2_req_valid`  out  1  held until `l2_req_ready`.
- `l2_req_ready`  in  1  L2 accepts the request.
- `l2_req_rw`  out  1  0 = read, 1 = write.
- `l2_req_addr`  out  LINE_ADDR_BITS  line address.
- `l2_req_data`  out  LINE_BITS  write data.
- `l2_resp_valid`  in  1  read data valid.
- `l2_resp_data`  in  LINE_BITS  read data.

## Operation
- **IDLE:** grant the first asserted `l1_req_valid` at or after `rr_ptr`, wrapping modulo NUM_CORES.
  - Pulse that core's `l1_req_ready`.
  - Latch request type, address, data and requester ID.
  - Set `rr_ptr` to grant+1, wrapping to 0 after NUM_CORES-1.
  - Go to SNOOP.
  - With no request asserted, stay in IDLE and keep `rr_ptr` unchanged.
- **SNOOP** (1 cycle): assert `l1_snoop_valid` on every core except the requester.
  - BUS_UPGR → ACK.
  - BUS_WB → L2_REQ (write).
  - BUS_RD / BUS_RDX → SNOOP_RESP.
- **SNOOP_RESP** (1 cycle): ignore the requester's own snoop bits.
  - Any dirty peer: the lowest-index dirty peer supplies data. Pulse `l1_resp_valid` with that data, latch it as flush data, and go to L2_REQ (write).
  - Else any shared peer: the lowest-index shared peer supplies data. Pulse `l1_resp_valid` and go to IDLE.
  - Else: go to L2_REQ (read).
  - `l1_resp_shared` = (BUS_RD) AND (any peer shared); it is always 0 for BUS_RDX.
- **L2_REQ:** hold `l2_req_valid` together with address, rw and data until `l2_req_ready`.
  - Write → IDLE.
  - Read → L2_WAIT.
- **L2_WAIT:** on `l2_resp_valid`, latch `l2_resp_data` and go to RESP.
- **RESP:** pulse `l1_resp_valid` with the latched data (`l1_resp_shared` = 0), then go to IDLE.
- **ACK:** pulse `l1_resp_valid` with data 0 and `l1_resp_shared` 0, then go to IDLE.
- No response is issued for BUS_WB or for a flush write.
- `l1_resp_id` always equals the latched requester ID.

## Timing
- Reset: state IDLE, `rr_ptr` 0, latched registers 0. Every valid/ready output is 0, and data/address/ID outputs are 0.
- Cycle numbering below: grant = cycle 0.
- Peer hit: response in cycle 2.
- UPGR ack: response in cycle 2.
- L2 read: `l2_req_valid` from cycle 2. The response comes 1 cycle after the `l2_resp_valid` cycle.
- Dirty hit: response in cycle 2, flush `l2_req_valid` from cycle 3.
- Back-to-back: the next grant is possible in the cycle after the transaction returns to IDLE.
- `l1_req_ready` is 0 in every non-IDLE state.
- `l2_resp_valid` outside L2_WAIT is ignored.
- `reset` mid-transaction: return to IDLE next cycle; no response and no flush is emitted.
- Snoop inputs are sampled only in SNOOP_RESP.

## Structure
- Shared package:
  - `bus_req_t` (existing).
  - New `bus_state_t` enum: IDLE, SNOOP, SNOOP_RESP, L2_REQ, L2_WAIT, RESP, ACK.
- Sub-module `rr_arbiter` (params NUM_CORES):
  - Inputs: `req`, `advance`.
  - Outputs: one-hot `grant`, `grant_id`, any-request flag.
  - Owns `rr_ptr`.
- Top module holds the FSM, the latched request registers and the lowest-index priority selects.

## Test plan
- **Round-robin fairness.** Stimulus: cores 0 and 2 hold BUS_RD continuously, all L2 misses. Required: grants in order 0, 2, 0, 2. From `rr_ptr`=3, core 0 wins before core 2.
- **Shared hit.** Stimulus: core 1 BUS_RD to 0x100; core 3 shared, data 0xA5…. Required: cycle 2 `l1_resp_valid`, id 1, data 0xA5…, shared 1; no `l2_req_valid`.
- **Dirty flush.** Stimulus: core 0 BUS_RDX; cores 2 and 3 both dirty. Required: core 2 data returned with shared 0; then an L2 write of core 2's data to the same address.
- **L2 miss.** Stimulus: BUS_RD, no sharers, `l2_req_ready` delayed 3 cycles, `l2_resp_valid` after 5 more. Required: `l2_req_valid` held stable for the full wait; `l1_resp_valid` exactly one cycle after `l2_resp_valid`.
- **Upgrade and writeback.** Stimulus: BUS_UPGR, then BUS_WB. Required: UPGR ack (data 0) in cycle 2; WB gives an L2 write with no L1 response.
- **Reset in L2_WAIT.** Stimulus: assert `reset`, then a stray `l2_resp_valid`. Required: all outputs 0, no response, the next request is granted normally.
